// File: rtl/matrix_bcd_scheduler.sv
// matrix_bcd_scheduler: per-frame scan of A, B, C = A*B into BCD digits.
// A double-dabble engine fills a shadow buffer that is committed on vblank.
module matrix_bcd_scheduler #(
  parameter int MATRIX_N = 3,
  parameter int MATRIX_M = 3,
  parameter int NUM_MAT  = 3,
  parameter int DIGITS   = 5,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  output logic              rd_req,
  output logic [1:0]        rd_mat,
  output logic [3:0]        rd_row,
  output logic [3:0]        rd_col,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic [NUM_MAT*MATRIX_N*MATRIX_M*DIGITS*4-1:0] bcd_bus,
  output logic              busy,
  output logic              frame_done,
  output logic              ovf
);

  localparam int NUM_E = NUM_MAT * MATRIX_N * MATRIX_M;
  localparam int BCD_W = DIGITS * 4;
  localparam int BUS_W = NUM_E * BCD_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int CMP_W = 64;

  function automatic logic [CMP_W-1:0] max_val(input int d);
    logic [CMP_W-1:0] r;
    r = 64'd1;
    for (int i = 0; i < d; i++)
      r = r * 64'd10;
    return r - 64'd1;
  endfunction

  localparam logic [CMP_W-1:0] MAX_VAL  = max_val(DIGITS);
  localparam logic [3:0]       COL_LAST = 4'(MATRIX_M - 1);
  localparam logic [3:0]       ROW_LAST = 4'(MATRIX_N - 1);
  localparam logic [1:0]       MAT_LAST = 2'(NUM_MAT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CONV,
    S_STORE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             state;
  logic               vblank_q;
  logic               pending;
  logic               kick;
  logic [DATA_W-1:0]  bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               sat_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BUS_W-1:0]   shadow;
  logic               shadow_ovf;

  logic               vb_rise;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   store_word;
  int                 e_idx;

  assign vb_rise = vblank & ~vblank_q;

  assign e_idx = int'(rd_row) * (MATRIX_M * NUM_MAT)
               + int'(rd_mat) * MATRIX_M
               + int'(rd_col);

  // store_word is MSD-first: digit 0 lands at the lowest bus nibble
  always_comb begin
    bcd_adj    = bcd_q;
    store_word = '0;
    for (int d = 0; d < DIGITS; d++)
      if (bcd_q[d*4 +: 4] >= 4'd5)
        bcd_adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
    for (int l = 0; l < DIGITS; l++)
      store_word[l*4 +: 4] = sat_q ? 4'd9
                                   : bcd_q[(DIGITS-1-l)*4 +: 4];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      vblank_q   <= 1'b0;
      pending    <= 1'b0;
      kick       <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
      shadow     <= '0;
      shadow_ovf <= 1'b0;
      rd_req     <= 1'b0;
      rd_mat     <= '0;
      rd_row     <= '0;
      rd_col     <= '0;
      bcd_bus    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      vblank_q   <= vblank;
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (kick || (vb_rise && !pending)) begin
            kick       <= 1'b0;
            state      <= S_REQ;
            rd_req     <= 1'b1;
            busy       <= 1'b1;
            rd_mat     <= '0;
            rd_row     <= '0;
            rd_col     <= '0;
            shadow_ovf <= 1'b0;
          end else if (vb_rise) begin
            // deferred frame goes out now, new scan starts next cycle
            bcd_bus    <= shadow;
            ovf        <= shadow_ovf;
            frame_done <= 1'b1;
            pending    <= 1'b0;
            kick       <= 1'b1;
          end
        end
        S_REQ: begin
          if (rd_ack) begin
            rd_req <= 1'b0;
            bin_q  <= rd_data;
            bcd_q  <= '0;
            cnt_q  <= '0;
            sat_q  <= CMP_W'(rd_data) > MAX_VAL;
            state  <= S_CONV;
          end
        end
        S_CONV: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST)
            state <= S_STORE;
        end
        S_STORE: begin
          for (int e = 0; e < NUM_E; e++)
            if (e_idx == e)
              shadow[e*BCD_W +: BCD_W] <= store_word;
          if (sat_q)
            shadow_ovf <= 1'b1;
          state <= S_NEXT;
        end
        S_NEXT: begin
          state  <= S_REQ;
          rd_req <= 1'b1;
          if (rd_col != COL_LAST) begin
            rd_col <= rd_col + 4'd1;
          end else begin
            rd_col <= '0;
            if (rd_row != ROW_LAST) begin
              rd_row <= rd_row + 4'd1;
            end else begin
              rd_row <= '0;
              if (rd_mat != MAT_LAST) begin
                rd_mat <= rd_mat + 2'd1;
              end else begin
                rd_mat <= '0;
                rd_req <= 1'b0;
                state  <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
          if (vblank) begin
            bcd_bus    <= shadow;
            ovf        <= shadow_ovf;
            frame_done <= 1'b1;
          end else begin
            pending <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_bcd_scheduler.sv
// Bench for matrix_bcd_scheduler: two lockstep instances (5 and 4 digits)
// fed by a random-latency responder, checked by a frame scoreboard.
module tb_matrix_bcd_scheduler;

  localparam int NE = 27;
  localparam int BA = NE * 5 * 4;
  localparam int BB = NE * 4 * 4;

  typedef struct {
    logic [BA-1:0] a;
    logic [BB-1:0] b;
    logic          ovf_a;
    logic          ovf_b;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          vblank;
  logic          rd_ack;
  logic [15:0]   rd_data_a, rd_data_b;
  logic          rd_req_a, rd_req_b;
  logic [1:0]    rd_mat_a, rd_mat_b;
  logic [3:0]    rd_row_a, rd_row_b;
  logic [3:0]    rd_col_a, rd_col_b;
  logic [BA-1:0] bcd_bus_a;
  logic [BB-1:0] bcd_bus_b;
  logic          busy_a, busy_b;
  logic          frame_done_a, frame_done_b;
  logic          ovf_a, ovf_b;

  int   total = 0;
  int   bad = 0;
  int   req_k = 0;
  int   fd_count = 0;
  int   stall_next = 0;
  int   vals_a [NE];
  int   vals_b [NE];
  exp_t exp_q [$];

  matrix_bcd_scheduler dut_a (
    .clk(clk), .reset(reset), .vblank(vblank),
    .rd_req(rd_req_a), .rd_mat(rd_mat_a),
    .rd_row(rd_row_a), .rd_col(rd_col_a),
    .rd_ack(rd_ack), .rd_data(rd_data_a),
    .bcd_bus(bcd_bus_a), .busy(busy_a),
    .frame_done(frame_done_a), .ovf(ovf_a)
  );

  matrix_bcd_scheduler #(.DIGITS(4)) dut_b (
    .clk(clk), .reset(reset), .vblank(vblank),
    .rd_req(rd_req_b), .rd_mat(rd_mat_b),
    .rd_row(rd_row_b), .rd_col(rd_col_b),
    .rd_ack(rd_ack), .rd_data(rd_data_b),
    .bcd_bus(bcd_bus_b), .busy(busy_b),
    .frame_done(frame_done_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [3:0] dig(input int v, input int d, input int l);
    if (v > p10(d) - 1) return 4'd9;
    return 4'((v / p10(d - 1 - l)) % 10);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // fill element values for the next scan and queue its expected frame
  task automatic launch(input int mode);
    exp_t x;
    x.a = '0; x.b = '0; x.ovf_a = 1'b0; x.ovf_b = 1'b0;
    for (int e = 0; e < NE; e++) begin
      case (mode)
        0: begin
          vals_a[e] = e * 37;
          vals_b[e] = e * 37;
        end
        1: begin
          vals_a[e] = int'($urandom_range(0, 65535));
          vals_b[e] = (e == 5) ? 12345 : int'($urandom_range(0, 9999));
        end
        2: begin
          vals_a[e] = int'($urandom_range(0, 65535));
          vals_b[e] = int'($urandom_range(0, 9999));
        end
        default: begin
          vals_a[e] = int'($urandom_range(0, 65535));
          vals_b[e] = int'($urandom_range(0, 20000));
        end
      endcase
      if (vals_a[e] > 99999) x.ovf_a = 1'b1;
      if (vals_b[e] > 9999) x.ovf_b = 1'b1;
      for (int l = 0; l < 5; l++)
        x.a[(e*5+l)*4 +: 4] = dig(vals_a[e], 5, l);
      for (int l = 0; l < 4; l++)
        x.b[(e*4+l)*4 +: 4] = dig(vals_b[e], 4, l);
    end
    exp_q.push_back(x);
    req_k = 0;
  endtask

  task automatic wait_fd(input string nm);
    int n = 0;
    while (!frame_done_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(frame_done_a), 64'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(busy_a), 64'd0);
  endtask

  task automatic rise_vblank();
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    vblank = 1'b1;
  endtask

  // datapath model: order check, random ack latency, stall and stray acks
  initial begin : responder
    int dly;
    int exp_m, exp_r, exp_c, ea;
    logic [9:0] addr;
    rd_ack = 1'b0;
    rd_data_a = '0;
    rd_data_b = '0;
    forever begin
      @(negedge clk);
      rd_ack = 1'b0;
      if (reset && rd_req_a) begin
        exp_m = req_k / 9;
        exp_r = (req_k % 9) / 3;
        exp_c = req_k % 3;
        chk("req_count", 64'(req_k < NE), 64'd1);
        chk("req_addr", {54'd0, rd_mat_a, rd_row_a, rd_col_a},
            {54'd0, 2'(exp_m), 4'(exp_r), 4'(exp_c)});
        chk("lockstep", {rd_req_b, rd_mat_b, rd_row_b, rd_col_b},
            {rd_req_a, rd_mat_a, rd_row_a, rd_col_a});
        addr = {rd_mat_a, rd_row_a, rd_col_a};
        dly = (stall_next > 0) ? stall_next : int'($urandom_range(0, 3));
        stall_next = 0;
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          chk("hold_req", {rd_req_a, busy_a, rd_mat_a, rd_row_a, rd_col_a},
              {2'b11, addr});
        end
        ea = int'(rd_row_a) * 9 + int'(rd_mat_a) * 3 + int'(rd_col_a);
        if (ea > NE - 1) ea = 0;
        rd_data_a = 16'(vals_a[ea]);
        rd_data_b = 16'(vals_b[ea]);
        rd_ack = 1'b1;
        req_k++;
      end else if ($urandom_range(0, 7) == 0) begin
        rd_ack = 1'b1;
        rd_data_a = 16'($urandom);
        rd_data_b = 16'($urandom);
      end
    end
  end

  initial begin : monitor
    exp_t x;
    logic [BA-1:0] last_a;
    logic [BB-1:0] last_b;
    logic last_oa, last_ob;
    last_a = '0; last_b = '0; last_oa = 1'b0; last_ob = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        last_a = '0; last_b = '0; last_oa = 1'b0; last_ob = 1'b0;
      end else begin
        chk("fd_lockstep", 64'(frame_done_b), 64'(frame_done_a));
        if (frame_done_a) begin
          fd_count++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_frame_done: got pulse want none");
          end else begin
            x = exp_q.pop_front();
            last_a = x.a; last_b = x.b;
            last_oa = x.ovf_a; last_ob = x.ovf_b;
          end
        end
        total++;
        if (bcd_bus_a !== last_a) begin
          bad++;
          $display("FAIL bus_a: got %h want %h", bcd_bus_a, last_a);
        end
        total++;
        if (bcd_bus_b !== last_b) begin
          bad++;
          $display("FAIL bus_b: got %h want %h", bcd_bus_b, last_b);
        end
        chk("ovf_pair", {62'd0, ovf_a, ovf_b}, {62'd0, last_oa, last_ob});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b0;
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl_a", {rd_req_a, rd_mat_a, rd_row_a, rd_col_a,
                         busy_a, frame_done_a, ovf_a}, 64'd0);
    chk("reset_ctrl_b", {rd_req_b, rd_mat_b, rd_row_b, rd_col_b,
                         busy_b, frame_done_b, ovf_b}, 64'd0);
    chk("reset_bus", 64'((bcd_bus_a != '0) || (bcd_bus_b != '0)), 64'd0);
    reset = 1'b1;

    // first frame: e*37, immediate commit
    launch(0);
    rise_vblank();
    chk("pre_start_busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    chk("start", {rd_req_a, busy_a, rd_mat_a, rd_row_a, rd_col_a},
        {2'b11, 10'd0});
    wait_fd("fd_frame1");
    chk("frame1_reqs", 64'(req_k), 64'(NE));
    chk("e26_digits", 64'(bcd_bus_a[26*20 +: 20]),
        64'({4'd2, 4'd6, 4'd9, 4'd0, 4'd0}));
    vblank = 1'b0;
    repeat (30) @(negedge clk);
    chk("frame1_once", 64'(fd_count), 64'd1);
    chk("frame1_idle", 64'(busy_a), 64'd0);

    // saturation in 4-digit instance, then cleared ovf
    launch(1);
    rise_vblank();
    wait_fd("fd_sat");
    chk("sat_digits", 64'(bcd_bus_b[5*16 +: 16]), 64'(16'h9999));
    chk("sat_ovf", 64'(ovf_b), 64'd1);
    launch(2);
    rise_vblank();
    wait_fd("fd_nosat");
    chk("ovf_clear", 64'(ovf_b), 64'd0);

    // deferred commit: vblank gone before scan end
    launch(3);
    rise_vblank();
    repeat (50) @(negedge clk);
    vblank = 1'b0;
    wait_idle("defer_idle");
    repeat (20) @(negedge clk);
    chk("defer_no_fd", 64'(fd_count), 64'd3);
    chk("defer_reqs", 64'(req_k), 64'(NE));
    launch(2);
    vblank = 1'b1;
    @(negedge clk);
    chk("defer_commit", {62'd0, frame_done_a, rd_req_a}, 64'b10);
    @(negedge clk);
    chk("defer_restart", {62'd0, rd_req_a, busy_a}, 64'b11);
    wait_fd("fd_after_defer");
    chk("after_defer_reqs", 64'(req_k), 64'(NE));

    // vblank pulse in the middle of a scan
    launch(3);
    rise_vblank();
    repeat (100) @(negedge clk);
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    vblank = 1'b1;
    wait_fd("fd_midedge");
    chk("midedge_reqs", 64'(req_k), 64'(NE));
    repeat (30) @(negedge clk);
    chk("midedge_no_restart", {62'd0, busy_a, rd_req_a}, 64'd0);
    chk("midedge_fd_count", 64'(fd_count), 64'd6);

    // reset during conversion
    launch(3);
    rise_vblank();
    repeat (8) @(negedge clk);
    chk("pre_reset_busy", 64'(busy_a), 64'd1);
    reset = 1'b0;
    vblank = 1'b0;
    @(negedge clk);
    chk("rst_ctrl_a", {rd_req_a, rd_mat_a, rd_row_a, rd_col_a,
                       busy_a, frame_done_a, ovf_a}, 64'd0);
    chk("rst_ctrl_b", {rd_req_b, rd_mat_b, rd_row_b, rd_col_b,
                       busy_b, frame_done_b, ovf_b}, 64'd0);
    chk("rst_bus", 64'((bcd_bus_a != '0) || (bcd_bus_b != '0)), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    launch(2);
    rise_vblank();
    wait_fd("fd_post_reset");
    chk("post_reset_reqs", 64'(req_k), 64'(NE));

    // long ack stall on the first element
    launch(2);
    stall_next = 100;
    rise_vblank();
    wait_fd("fd_stall");
    chk("stall_reqs", 64'(req_k), 64'(NE));

    vblank = 1'b0;
    repeat (10) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
